goldschmidt_ctrl: RTL

- Sequencer and operand manager for the two-stage Goldschmidt divider datapath.
- Accepts a divide request (N, D, IA) through a start handshake.
- Each iteration, drives the datapath's kSelect, ndSelect, N, D and IA inputs, and captures the products from the datapath's 32-bit result as the next-iteration operands.
- After ITERS iterations, presents the final quotient product on a valid/ready output handshake.

---
 rtl/goldschmidt_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/goldschmidt_ctrl.sv
// Sequencer and operand manager for the two-stage Goldschmidt divider datapath.
// It issues D then N to the datapath each iteration and captures the products
// as the next-iteration operands. The final N product is presented on a
// valid/ready handshake.
module goldschmidt_ctrl #(
  parameter int unsigned ITERS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] n_in,
  input  logic [15:0] d_in,
  input  logic [15:0] ia_in,
  output logic        busy,
  output logic [15:0] dp_n,
  output logic [15:0] dp_d,
  output logic [15:0] dp_ia,
  output logic        kSelect,
  output logic        ndSelect,
  input  logic [31:0] dp_result,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [31:0] q_out,
  output logic        err
);

  localparam int unsigned ITER_W = (ITERS < 1) ? 1 : $clog2(ITERS + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_D = 3'd1;
  localparam logic [2:0] ISSUE_N = 3'd2;
  localparam logic [2:0] CAP_D   = 3'd3;
  localparam logic [2:0] CAP_N   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       d_q, d_d;
  logic [15:0]       ia_q, ia_d;
  logic [31:0]       q_q, q_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ksel_q, ksel_d;
  logic              ndsel_q, ndsel_d;
  logic              qv_q, qv_d;

  // Next-state, operand capture and output decode from the next state.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    n_d     = n_q;
    d_d     = d_q;
    ia_d    = ia_q;
    q_d     = q_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (d_in != 16'd0) begin
            n_d     = n_in;
            d_d     = d_in;
            ia_d    = ia_in;
            iter_d  = '0;
            err_d   = 1'b0;
            state_d = ISSUE_D;
          end else begin
            q_d     = 32'hFFFF_FFFF;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE_D: state_d = ISSUE_N;
      ISSUE_N: state_d = CAP_D;
      CAP_D: begin
        d_d     = dp_result[30:15];
        state_d = CAP_N;
      end
      CAP_N: begin
        n_d = dp_result[30:15];
        q_d = dp_result;
        if (iter_q == ITER_LAST) begin
          state_d = DONE;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = ISSUE_D;
        end
      end
      DONE: begin
        if (q_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ndsel_d = (state_d != ISSUE_D);
    ksel_d  = (state_d == ISSUE_D) && (iter_d == '0);
    qv_d    = (state_d == DONE);
  end

  // State and registered outputs; async active-low reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      n_q     <= '0;
      d_q     <= '0;
      ia_q    <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ksel_q  <= 1'b0;
      ndsel_q <= 1'b1;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      n_q     <= n_d;
      d_q     <= d_d;
      ia_q    <= ia_d;
      q_q     <= q_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ksel_q  <= ksel_d;
      ndsel_q <= ndsel_d;
      qv_q    <= qv_d;
    end
  end

  assign busy     = busy_q;
  assign dp_n     = n_q;
  assign dp_d     = d_q;
  assign dp_ia    = ia_q;
  assign kSelect  = ksel_q;
  assign ndSelect = ndsel_q;
  assign q_valid  = qv_q;
  assign q_out    = q_q;
  assign err      = err_q;

endmodule
